lp_tree_deserializer: RTL and testbench

Receive-side counterpart of lp_tree_serializer. It captures a framed serial bit stream on SERIAL_IN and reassembles it into a WIDTH-bit parallel word. When TREE_ORDER=1 it undoes the tree serializer's bit-reversed index ordering. It sits at the far end of the serial link and delivers PAR_OUT with a one-cycle PAR_VALID strobe per good frame.

---
 rtl/lp_tree_deserializer.sv | 130 +++++++++++++
 tb/tb_lp_tree_deserializer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lp_tree_deserializer.sv
// lp_tree_deserializer: receive side of the tree serial link.
// Captures a framed bit stream (start=1, WIDTH data bits, stop=0) and
// reassembles it into a parallel word. When TREE_ORDER=1 the output index
// is the bit-reverse of the serial index, undoing the tree serializer.
module lp_tree_deserializer #(
  parameter int WIDTH      = 16,
  parameter bit TREE_ORDER = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             VPWR,
  input  logic             VGND,
  input  logic             SERIAL_IN,
  output logic [WIDTH-1:0] PAR_OUT,
  output logic             PAR_VALID,
  output logic             FRAME_ERR
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] mapped;
  logic             frame_good;
  logic             frame_bad;

  // Power pins carry no logic; fold them into a sink so they are not dangling.
  logic unused_power;
  assign unused_power = VPWR ^ VGND;

  // Reverse the bit order of a serial index over log2(WIDTH) bits.
  function automatic logic [CW-1:0] rev_idx(input logic [CW-1:0] s);
    logic [CW-1:0] r;
    for (int k = 0; k < CW; k++) begin
      r[k] = s[CW-1-k];
    end
    return r;
  endfunction

  // Map the shift register (serial index order) onto output bit positions.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    mapped = '0;
    for (int s = 0; s < WIDTH; s++) begin
      if (TREE_ORDER) begin
        mapped[rev_idx(CW'(s))] = sr[s];
      end else begin
        mapped[s] = sr[s];
      end
    end
  end

  // Next-state logic and stop-bit qualification.
  always_comb begin
    state_nxt  = state;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (SERIAL_IN) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == LAST) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        // The stop-bit sample is consumed here; a bad 1 is never reused
        // as a start bit because IDLE only samples from the next cycle.
        state_nxt  = IDLE;
        frame_good = ~SERIAL_IN;
        frame_bad  = SERIAL_IN;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: bit counter, shift register, output word and strobes.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_cnt   <= '0;
      sr        <= '0;
      PAR_OUT   <= '0;
      PAR_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      PAR_VALID <= frame_good;
      FRAME_ERR <= frame_bad;
      if (frame_good) begin
        PAR_OUT <= mapped;
      end
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        sr[bit_cnt] <= SERIAL_IN;
        // Hold at terminal count instead of wrapping; the value is unused
        // until IDLE clears it for the next frame.
        if (bit_cnt != LAST) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lp_tree_deserializer.sv
// Testbench for lp_tree_deserializer: drives framed serial traffic into two
// instances (tree order and straight order) sharing one line, and checks
// them through per-instance scoreboards fed by a reference model.
module tb_lp_tree_deserializer;

  localparam int W = 16;

  typedef struct {
    bit          err;
    logic [15:0] word;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        serial_in;
  logic [15:0] out1, out0;
  logic        valid1, valid0, err1, err0;

  exp_t        q1[$];
  exp_t        q0[$];
  logic [15:0] hold[2];
  int          cyc;
  int          total;
  int          bad;

  lp_tree_deserializer #(.WIDTH(W), .TREE_ORDER(1'b1)) dut1 (
    .CLK(clk), .RESET(rst), .VPWR(1'b1), .VGND(1'b0), .SERIAL_IN(serial_in),
    .PAR_OUT(out1), .PAR_VALID(valid1), .FRAME_ERR(err1)
  );

  lp_tree_deserializer #(.WIDTH(W), .TREE_ORDER(1'b0)) dut0 (
    .CLK(clk), .RESET(rst), .VPWR(1'b1), .VGND(1'b0), .SERIAL_IN(serial_in),
    .PAR_OUT(out0), .PAR_VALID(valid0), .FRAME_ERR(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit reversal of a 4-bit serial index, computed arithmetically.
  function automatic int rev4(input int s);
    int r = 0;
    for (int k = 0; k < 4; k++) r = (r << 1) | ((s >> k) & 1);
    return r;
  endfunction

  // Monitor one instance: pop and compare on any strobe, else check hold.
  task automatic mon(input int id, input logic v, input logic e, input logic [15:0] o);
    exp_t x;
    int   qs;
    string tag;
    tag = (id == 1) ? "tree" : "straight";
    check({tag, "_exclusive_strobes"}, {31'b0, v & e}, 32'd0);
    if (v || e) begin
      qs = (id == 1) ? q1.size() : q0.size();
      check({tag, "_strobe_expected"}, {31'b0, qs > 0}, 32'd1);
      if (qs > 0) begin
        x = (id == 1) ? q1.pop_front() : q0.pop_front();
        check({tag, "_strobe_kind_err"}, {31'b0, e}, {31'b0, x.err});
        check({tag, "_strobe_cycle"}, cyc, x.cyc);
        if (x.err) begin
          check({tag, "_par_out_kept_on_err"}, {16'b0, o}, {16'b0, hold[id]});
        end else begin
          check({tag, "_par_out"}, {16'b0, o}, {16'b0, x.word});
          hold[id] = x.word;
        end
      end
    end else begin
      if (o !== hold[id]) check({tag, "_par_out_hold"}, {16'b0, o}, {16'b0, hold[id]});
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(1, valid1, err1, out1);
      mon(0, valid0, err0, out0);
    end
  end

  task automatic drive(input logic b);
    @(posedge clk);
    #1 serial_in = b;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    serial_in = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    q1.delete();
    q0.delete();
    hold[0] = 16'h0000;
    hold[1] = 16'h0000;
  endtask

  // Send one frame whose data bits are given in serial index order.
  task automatic send_frame(input logic [15:0] bits, input logic stop_bit, input int gap);
    exp_t e1, e0;
    drive(1'b1);
    for (int s = 0; s < W; s++) drive(bits[s]);
    drive(stop_bit);
    e1.err = stop_bit;
    e0.err = stop_bit;
    e1.word = 16'h0000;
    for (int s = 0; s < W; s++) e1.word[rev4(s)] = bits[s];
    e0.word = bits;
    e1.cyc = cyc + 1;
    e0.cyc = cyc + 1;
    q1.push_back(e1);
    q0.push_back(e0);
    for (int g = 0; g < gap; g++) drive(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w, bits;
    total = 0;
    bad = 0;
    cyc = 0;
    rst = 1'b1;
    serial_in = 1'b0;
    hold[0] = 16'h0000;
    hold[1] = 16'h0000;
    repeat (3) @(posedge clk);
    do_reset();

    @(negedge clk);
    check("reset_par_out_tree", {16'b0, out1}, 32'd0);
    check("reset_par_out_straight", {16'b0, out0}, 32'd0);
    check("reset_valid", {30'b0, valid1, valid0}, 32'd0);
    check("reset_err", {30'b0, err1, err0}, 32'd0);

    // Idle line: no strobes expected.
    repeat (10) drive(1'b0);

    // Single set bit at s0, then at s1.
    send_frame(16'h0001, 1'b0, 2);
    send_frame(16'h0002, 1'b0, 2);

    // All ones, then a bad stop bit with zero data.
    send_frame(16'hFFFF, 1'b0, 2);
    send_frame(16'h0000, 1'b1, 3);

    // Reset after data bit 8 of an all-ones frame.
    drive(1'b1);
    for (int s = 0; s <= 8; s++) drive(1'b1);
    do_reset();
    @(negedge clk);
    check("midframe_reset_par_out", {16'b0, out1}, 32'd0);
    repeat (W + 4) drive(1'b0);
    send_frame(16'h0001, 1'b0, 2);

    // Back-to-back frames, no idle between them.
    send_frame(16'hC5AF, 1'b0, 0);
    send_frame(16'h1234, 1'b0, 3);

    // Back-to-back with a bad stop followed immediately by a good frame.
    send_frame(16'hA5A5, 1'b1, 0);
    send_frame(16'h8001, 1'b0, 2);

    // Loopback-style traffic: words framed as the tree serializer sends them.
    for (int n = 0; n < 10; n++) begin
      w = 16'($urandom);
      for (int s = 0; s < W; s++) bits[s] = w[rev4(s)];
      send_frame(bits, 1'b0, int'($urandom_range(0, 3)));
    end

    repeat (25) drive(1'b0);
    check("tree_queue_drained", q1.size(), 32'd0);
    check("straight_queue_drained", q0.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
